// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, and
// reports unsigned borrow, signed overflow, signed less-than and zero flags.
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             lt_s,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             lt_q, lt_d;
    logic             zero_q, zero_d;

    logic             d_bit;
    logic             bout_bit;

    // One-bit full subtractor; returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bi);
        logic dd;
        logic bo;
        dd = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, dd};
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        lt_d    = lt_q;
        zero_d  = zero_q;

        {bout_bit, d_bit} = sub_bit(a_q[0], b_q[0], bin_q);

        unique case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                bin_d  = bout_bit;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Sign bits of the operands sit in bit 0 on the final cycle.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
                    lt_d    = d_bit ^ ovf_d;
                    zero_d  = ~|diff_d;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            lt_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            lt_q    <= lt_d;
            zero_q  <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = bin_q;
    assign overflow = ovf_q;
    assign lt_s     = lt_q;
    assign zero     = zero_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to subtract a - b; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  final borrow-out; equals unsigned a < b.
REQ-011 SHALL have port overflow  output  1  signed two's-complement overflow of a - b.
REQ-012 SHALL have port lt_s  output  1  signed a < b.
REQ-013 SHALL have port zero  output  1  diff == 0 (a == b).

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL accept start only in IDLE or DONE; on acceptance capture a, b into shift registers, clear borrow flop to 0, clear bit counter, enter SHIFT.
REQ-016 SHALL ignore start while in SHIFT; captured operands and progress SHALL be unaffected.
REQ-017 SHALL, in SHIFT, process one bit per cycle LSB first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin); shift d into diff MSB side; update borrow flop with bout.
REQ-018 SHALL leave SHIFT after exactly WIDTH bit cycles and enter DONE; done high and all results valid for exactly the first cycle in DONE.
REQ-019 SHALL give latency: start accepted at edge N -> done high during the cycle after edge N+WIDTH.
REQ-020 SHALL drive busy high exactly while in SHIFT (WIDTH cycles per operation).
REQ-021 SHALL go DONE -> IDLE on the next edge unless start is high, in which case DONE -> SHIFT (back-to-back operation, no idle cycle).
REQ-022 SHALL hold diff, borrow, overflow, lt_s, zero stable from DONE until the next accepted start; during SHIFT their values are don't-care except diff, which holds partial shift contents.
REQ-023 SHALL compute overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using captured operands.
REQ-024 SHALL compute lt_s = diff[MSB] ^ overflow; zero = ~|diff.
REQ-025 SHALL wrap diff modulo 2^WIDTH with no saturation.

Reset
REQ-026 SHALL, on rst_n low, immediately (without clock) force state IDLE, busy 0, done 0, diff 0, borrow 0, overflow 0, lt_s 0, zero 0, counter 0, borrow flop 0.
REQ-027 SHALL abort any in-progress operation on reset; no done pulse SHALL be produced for the aborted operation.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-029 SHALL test a=5, b=3 -> after 32 busy cycles done pulse; diff=0x00000002, borrow=0, overflow=0, lt_s=0, zero=0.
REQ-030 SHALL test a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, overflow=0, lt_s=1, zero=0.
REQ-031 SHALL test a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, overflow=1, lt_s=1; and a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, overflow=1, lt_s=0, borrow=1.
REQ-032 SHALL test a=b=0x12345678 -> diff=0, zero=1, borrow=0, lt_s=0.
REQ-033 SHALL test start pulsed with new operands at cycle 10 of busy -> ignored, result of original operands; start held high in DONE -> next operation begins with no idle cycle.
REQ-034 SHALL test rst_n low at busy cycle 16 -> all outputs 0 asynchronously, no done pulse; fresh start then completes correctly in 32 cycles.
